// File: rtl/fp_round_pack_pkg.sv
// Shared constants, classification codes and stage payload for fp_round_pack.
package fp_round_pack_pkg;

  localparam int unsigned EXP    = 8;
  localparam int unsigned FRAC   = 23;
  localparam int unsigned HEXP   = 5;
  localparam int unsigned HFRAC  = 10;
  localparam int unsigned MANT_W = FRAC + 4;
  localparam int unsigned FLAG_W = 5;
  localparam int unsigned WORD_W = 32;

  // Flag bit positions; bits 3 and 4 are carried through untouched.
  localparam int unsigned F_INEXACT   = 0;
  localparam int unsigned F_UNDERFLOW = 1;
  localparam int unsigned F_OVERFLOW  = 2;

  localparam logic [FLAG_W-1:0] FM_NX = FLAG_W'(1) << F_INEXACT;
  localparam logic [FLAG_W-1:0] FM_UF = FLAG_W'(1) << F_UNDERFLOW;
  localparam logic [FLAG_W-1:0] FM_OF = FLAG_W'(1) << F_OVERFLOW;

  localparam logic RM_RNE = 1'b0;
  localparam logic RM_RTZ = 1'b1;

  localparam logic [31:0] QNAN_S = 32'h7FC0_0000;
  localparam logic [15:0] QNAN_H = 16'h7E00;
  localparam logic [31:0] MAXF_S = 32'h7F7F_FFFF;
  localparam logic [15:0] MAXF_H = 16'h7BFF;
  localparam logic [31:0] INF_S  = 32'h7F80_0000;
  localparam logic [15:0] INF_H  = 16'h7C00;

  localparam int unsigned HALF_REBIAS = 112;

  typedef enum logic [2:0] {
    K_NORM = 3'd0,
    K_NAN  = 3'd1,
    K_INF  = 3'd2,
    K_ZERO = 3'd3,
    K_HOVF = 3'd4,
    K_HUNF = 3'd5
  } kind_t;

  // Stage-1 payload: unrounded word plus everything stage 2 needs to finish it.
  typedef struct packed {
    kind_t               kind;
    logic                sign;
    logic                mode_fp;
    logic                rtz;
    logic                inc;
    logic                inexact;
    logic [WORD_W-1:0]   base;
    logic [FLAG_W-1:0]   flags;
  } s1_t;

  // Place a signed magnitude into the single word or the low half of the word.
  function automatic logic [WORD_W-1:0] pack_signed(input logic mode_fp, input logic sign,
                                                    input logic [31:0] mag_s,
                                                    input logic [15:0] mag_h);
    if (mode_fp) return mag_s | {sign, 31'h0};
    return {16'h0, mag_h | {sign, 15'h0}};
  endfunction

endpackage

// File: rtl/fp_round_inc.sv
// Rounding increment and inexact detection for one target format.
module fp_round_inc
  import fp_round_pack_pkg::*;
(
  input  logic lsb,
  input  logic g,
  input  logic s,
  input  logic round_mode,
  output logic inc,
  output logic inexact
);

  assign inc     = (round_mode == RM_RNE) ? (g & (s | lsb)) : 1'b0;
  assign inexact = g | s;

endmodule

// File: rtl/fp_round_pack.sv
// Two-stage valid/ready round-and-pack of an unpacked FP result into single or half.
module fp_round_pack
  import fp_round_pack_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  output logic              ready_out,
  input  logic              sign_in,
  input  logic [EXP-1:0]    exp_in,
  input  logic [MANT_W-1:0] mant_in,
  input  logic [FLAG_W-1:0] flags_in,
  input  logic              mode_fp_in,
  input  logic              round_mode,
  output logic              valid_out,
  input  logic              ready_in,
  output logic [WORD_W-1:0] result,
  output logic [FLAG_W-1:0] flags_out,
  output logic              mode_fp_out
);

  logic              v1, v2, en1, en2;
  logic signed [9:0] e_h;
  logic              inc_s, nx_s, inc_h, nx_h;
  s1_t               s1_d, s1_q;
  logic [WORD_W-1:0] sum, res_d;
  logic [FLAG_W-1:0] flg_d;

  assign en2       = ~v2 | ready_in;
  assign en1       = ~v1 | en2;
  assign ready_out = en1;
  assign valid_out = v2;

  fp_round_inc u_inc_s (
    .lsb        (mant_in[3]),
    .g          (mant_in[2]),
    .s          (mant_in[1] | mant_in[0]),
    .round_mode (round_mode),
    .inc        (inc_s),
    .inexact    (nx_s)
  );

  fp_round_inc u_inc_h (
    .lsb        (mant_in[16]),
    .g          (mant_in[15]),
    .s          (|mant_in[14:0]),
    .round_mode (round_mode),
    .inc        (inc_h),
    .inexact    (nx_h)
  );

  // Stage 1: classify the tuple and build the unrounded word for the target format.
  always_comb begin
    e_h          = 10'(exp_in) - 10'(HALF_REBIAS);
    s1_d         = '0;
    s1_d.sign    = sign_in;
    s1_d.mode_fp = mode_fp_in;
    s1_d.rtz     = (round_mode == RM_RTZ);
    s1_d.flags   = flags_in;
    if (mode_fp_in) begin
      s1_d.base    = {sign_in, exp_in, mant_in[FRAC+2:3]};
      s1_d.inc     = inc_s;
      s1_d.inexact = nx_s;
    end else begin
      s1_d.base    = {16'h0, sign_in, e_h[HEXP-1:0], mant_in[FRAC+2 -: HFRAC]};
      s1_d.inc     = inc_h;
      s1_d.inexact = nx_h;
    end
    if (exp_in == '1)
      s1_d.kind = (mant_in[FRAC+2:3] != '0) ? K_NAN : K_INF;
    else if (exp_in == '0 && mant_in == '0)
      s1_d.kind = K_ZERO;
    else if (!mode_fp_in && e_h >= 10'sd31)
      s1_d.kind = K_HOVF;
    else if (!mode_fp_in && e_h <= 10'sd0)
      s1_d.kind = K_HUNF;
    else
      s1_d.kind = K_NORM;
  end

  // Stage 1 register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1   <= 1'b0;
      s1_q <= '0;
    end else if (en1) begin
      v1 <= valid_in;
      if (valid_in) s1_q <= s1_d;
    end
  end

  // Stage 2: apply the increment (carry ripples into the exponent) and resolve specials.
  always_comb begin
    sum   = s1_q.base + WORD_W'(s1_q.inc);
    res_d = sum;
    flg_d = s1_q.flags | (s1_q.inexact ? FM_NX : '0);
    unique case (s1_q.kind)
      K_NAN: begin
        res_d = s1_q.mode_fp ? QNAN_S : {16'h0, QNAN_H};
        flg_d = s1_q.flags;
      end
      K_INF: begin
        if (s1_q.flags[F_OVERFLOW] && s1_q.rtz)
          res_d = pack_signed(s1_q.mode_fp, s1_q.sign, MAXF_S, MAXF_H);
        else
          res_d = pack_signed(s1_q.mode_fp, s1_q.sign, INF_S, INF_H);
        flg_d = s1_q.flags;
      end
      K_ZERO: begin
        res_d = pack_signed(s1_q.mode_fp, s1_q.sign, 32'h0, 16'h0);
        flg_d = s1_q.flags;
      end
      K_HOVF: begin
        res_d = pack_signed(1'b0, s1_q.sign, 32'h0, s1_q.rtz ? MAXF_H : INF_H);
        flg_d = s1_q.flags | FM_OF | FM_NX;
      end
      K_HUNF: begin
        res_d = pack_signed(1'b0, s1_q.sign, 32'h0, 16'h0);
        flg_d = s1_q.flags | FM_UF | FM_NX;
      end
      default: begin
        // A rounding carry into the all-ones exponent lands exactly on Inf.
        if ((s1_q.mode_fp && sum[30:23] == '1) || (!s1_q.mode_fp && sum[14:10] == '1))
          flg_d = flg_d | FM_OF | FM_NX;
      end
    endcase
  end

  // Stage 2 register; outputs hold while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2          <= 1'b0;
      result      <= '0;
      flags_out   <= '0;
      mode_fp_out <= 1'b0;
    end else if (en2) begin
      v2 <= v1;
      if (v1) begin
        result      <= res_d;
        flags_out   <= flg_d;
        mode_fp_out <= s1_q.mode_fp;
      end
    end
  end

endmodule
